// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: IR opcode, memory handshake and datapath controls
// between the multi-cycle MIPS control FSM and its datapath.
interface mips_multicycle_control_if;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic        ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        illegal_op;
    logic [31:0] instr_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op, instr_count
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multi-cycle MIPS control FSM sequencing fetch, decode,
// execute, memory access and write-back, with a retired-fetch counter.
module mips_multicycle_control (
    input logic clk,
    input logic rst_n,
    mips_multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
        EXECUTE, ALU_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB
    } state_t;

    typedef struct packed {
        logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
    } ctl_t;

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08;

    state_t      st, nxt;
    ctl_t        ctl;
    logic [31:0] cnt;
    logic        fetch_done;

    assign fetch_done = st == FETCH && bus.mem_ready;

    // Moore controls for a state; registered against the next state so they line up with it
    function automatic ctl_t decode(state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:             begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            DECODE:            c.alu_src_b = 2'b11;
            MEM_ADDR, ADDI_EX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEM_READ:          begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            MEM_WB:            begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            MEM_WRITE:         begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            EXECUTE:           begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            ALU_WB:            begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            BRANCH:            begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
            JUMP:              begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            ADDI_WB:           c.reg_write = 1'b1;
            default:           ;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = FETCH;
        case (st)
            FETCH:     nxt = bus.mem_ready ? DECODE : FETCH;
            DECODE:    nxt = bus.opcode == OP_R    ? EXECUTE  :
                             bus.opcode == OP_LW   ? MEM_ADDR :
                             bus.opcode == OP_SW   ? MEM_ADDR :
                             bus.opcode == OP_BEQ  ? BRANCH   :
                             bus.opcode == OP_J    ? JUMP     :
                             bus.opcode == OP_ADDI ? ADDI_EX  : FETCH;
            MEM_ADDR:  nxt = bus.opcode == OP_LW ? MEM_READ : MEM_WRITE;
            MEM_READ:  nxt = bus.mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: nxt = bus.mem_ready ? FETCH : MEM_WRITE;
            EXECUTE:   nxt = ALU_WB;
            ADDI_EX:   nxt = ADDI_WB;
            default:   nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st  <= IDLE;
            ctl <= '0;
            cnt <= '0;
        end else begin
            st  <= nxt;
            ctl <= decode(nxt);
            if (fetch_done) cnt <= cnt + 32'd1;
        end
    end

    assign bus.pc_write      = ctl.pc_write | fetch_done;
    assign bus.ir_write      = fetch_done;
    assign bus.pc_write_cond = ctl.pc_write_cond;
    assign bus.i_or_d        = ctl.i_or_d;
    assign bus.mem_read      = ctl.mem_read;
    assign bus.mem_write     = ctl.mem_write;
    assign bus.mem_to_reg    = ctl.mem_to_reg;
    assign bus.reg_dst       = ctl.reg_dst;
    assign bus.reg_write     = ctl.reg_write;
    assign bus.alu_src_a     = ctl.alu_src_a;
    assign bus.alu_src_b     = ctl.alu_src_b;
    assign bus.alu_op        = ctl.alu_op;
    assign bus.pc_source     = ctl.pc_source;
    assign bus.state         = st;
    assign bus.illegal_op    = st == DECODE && !(bus.opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
    assign bus.instr_count   = cnt;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed checks of state sequencing, per-state
// controls, memory stalls, illegal opcode, counter wrap and mid-instruction reset.
module tb_mips_multicycle_control;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    mips_multicycle_control_if bus ();
    mips_multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0]}
    localparam logic [15:0] TBL [13] = '{
        16'b0000000000_00_00_00,  // IDLE
        16'b0001000000_01_00_00,  // FETCH, mem_ready=0
        16'b0000000000_11_00_00,  // DECODE
        16'b0000000001_10_00_00,  // MEM_ADDR
        16'b0011000000_00_00_00,  // MEM_READ
        16'b0000001010_00_00_00,  // MEM_WB
        16'b0010100000_00_00_00,  // MEM_WRITE
        16'b0000000001_00_10_00,  // EXECUTE
        16'b0000000110_00_00_00,  // ALU_WB
        16'b0100000001_00_01_01,  // BRANCH
        16'b1000000000_00_00_10,  // JUMP
        16'b0000000001_10_00_00,  // ADDI_EX
        16'b0000000010_00_00_00   // ADDI_WB
    };
    localparam logic [15:0] IRPC = 16'b1000010000_00_00_00;

    logic [15:0] obs;
    assign obs = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                  bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_op, bus.pc_source};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check the current cycle against state s, then advance one clock.
    task automatic step(input int s, input logic ill);
        logic [15:0] e;
        #1;
        e = TBL[s] | ((s == 1 && bus.mem_ready) ? IRPC : 16'h0);
        chk($sformatf("state(exp %0d)", s), {28'h0, bus.state}, s);
        chk($sformatf("ctl(state %0d)", s), {16'h0, obs}, {16'h0, e});
        chk($sformatf("illegal(state %0d)", s), {31'h0, bus.illegal_op}, {31'h0, ill});
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input int seq[5], input int n);
        bus.opcode = op;
        for (int i = 0; i < n; i++) step(seq[i], 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("count_reset", bus.instr_count, 32'd0);
        step(0, 1'b0);

        instr(6'h00, '{1, 2, 7, 8, 0}, 4);
        instr(6'h23, '{1, 2, 3, 4, 5}, 5);
        instr(6'h2b, '{1, 2, 3, 6, 0}, 4);
        instr(6'h04, '{1, 2, 9, 0, 0}, 3);
        instr(6'h02, '{1, 2, 10, 0, 0}, 3);
        instr(6'h08, '{1, 2, 11, 12, 0}, 4);
        chk("count_six", bus.instr_count, 32'd6);

        bus.opcode = 6'h3f;
        bus.mem_ready = 1'b0;
        step(1, 1'b0);
        step(1, 1'b0);
        step(1, 1'b0);
        bus.mem_ready = 1'b1;
        step(1, 1'b0);
        chk("count_stall", bus.instr_count, 32'd7);
        step(2, 1'b1);
        chk("illegal_to_fetch", {28'h0, bus.state}, 32'd1);

        bus.opcode = 6'h2b;
        step(1, 1'b0);
        step(2, 1'b0);
        step(3, 1'b0);
        bus.mem_ready = 1'b0;
        step(6, 1'b0);
        step(6, 1'b0);
        bus.mem_ready = 1'b1;
        step(6, 1'b0);
        chk("sw_stall_fetch", {28'h0, bus.state}, 32'd1);
        chk("count_sw", bus.instr_count, 32'd8);

        dut.cnt = 32'hFFFF_FFFF;
        #1;
        chk("count_preset", bus.instr_count, 32'hFFFF_FFFF);
        bus.opcode = 6'h02;
        step(1, 1'b0);
        chk("count_wrap", bus.instr_count, 32'd0);
        step(2, 1'b0);
        step(10, 1'b0);

        bus.opcode = 6'h23;
        step(1, 1'b0);
        step(2, 1'b0);
        step(3, 1'b0);
        bus.mem_ready = 1'b0;
        step(4, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("count_midreset", bus.instr_count, 32'd0);
        step(0, 1'b0);
        step(1, 1'b0);
        chk("count_after_reset", bus.instr_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
